// File: rtl/rs_bank.sv
// Reservation-station bank: holds waiting instructions, snoops the CDB for
// operands and issues the lowest-index ready entry to its execution unit.
module rs_bank #(
    parameter int              DEPTH    = 8,
    parameter int              WIDTH    = 32,
    parameter int              TAG_W    = 8,
    parameter int              OP_W     = 2,
    parameter logic [TAG_W-1:0] TAG_BASE = 'h20,
    localparam int             CW       = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc_valid,
    output logic             alloc_ready,
    input  logic [OP_W-1:0]  alloc_op,
    input  logic [TAG_W-1:0] alloc_q1,
    input  logic [WIDTH-1:0] alloc_v1,
    input  logic             alloc_r1,
    input  logic [TAG_W-1:0] alloc_q2,
    input  logic [WIDTH-1:0] alloc_v2,
    input  logic             alloc_r2,
    output logic [TAG_W-1:0] alloc_tag,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [WIDTH-1:0] cdb_data,
    output logic             issue_valid,
    input  logic             issue_ready,
    output logic [OP_W-1:0]  issue_op,
    output logic [WIDTH-1:0] issue_a,
    output logic [WIDTH-1:0] issue_b,
    output logic [TAG_W-1:0] issue_tag,
    input  logic             flush,
    output logic [CW-1:0]    count
);

    localparam int IW = $clog2(DEPTH);
    localparam logic [63:0] TAG_LAST =
        64'(TAG_BASE) + 64'(DEPTH) - 64'd1;

    if (TAG_LAST >= (64'd1 << TAG_W)) begin : g_tag_err
        $error("rs_bank: tag range exceeds TAG_W");
    end
    if (DEPTH < 2 || DEPTH > 32) begin : g_depth_err
        $error("rs_bank: DEPTH out of range");
    end

    logic [DEPTH-1:0] busy_q, busy_d;
    logic [DEPTH-1:0] r1_q, r1_d;
    logic [DEPTH-1:0] r2_q, r2_d;
    logic [OP_W-1:0]  op_q [DEPTH];
    logic [OP_W-1:0]  op_d [DEPTH];
    logic [TAG_W-1:0] q1_q [DEPTH];
    logic [TAG_W-1:0] q1_d [DEPTH];
    logic [TAG_W-1:0] q2_q [DEPTH];
    logic [TAG_W-1:0] q2_d [DEPTH];
    logic [WIDTH-1:0] v1_q [DEPTH];
    logic [WIDTH-1:0] v1_d [DEPTH];
    logic [WIDTH-1:0] v2_q [DEPTH];
    logic [WIDTH-1:0] v2_d [DEPTH];
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [DEPTH-1:0] rdy;
    logic [IW-1:0]    free_idx;
    logic [IW-1:0]    iss_idx;
    logic             do_alloc;
    logic             do_issue;
    logic             byp1;
    logic             byp2;

    assign rdy = busy_q & r1_q & r2_q;

    // Downward scans so the lowest matching index wins.
    always_comb begin
        free_idx = '0;
        iss_idx  = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!busy_q[i]) free_idx = IW'(i);
            if (rdy[i])     iss_idx  = IW'(i);
        end
    end

    assign alloc_ready = ~&busy_q;
    assign alloc_tag   = TAG_BASE + TAG_W'(free_idx);
    assign issue_valid = |rdy;
    assign issue_op    = op_q[iss_idx];
    assign issue_a     = v1_q[iss_idx];
    assign issue_b     = v2_q[iss_idx];
    assign issue_tag   = TAG_BASE + TAG_W'(iss_idx);
    assign count       = cnt_q;

    assign do_alloc = alloc_valid && alloc_ready && !flush;
    assign do_issue = issue_valid && issue_ready && !flush;
    assign byp1     = cdb_valid && (cdb_tag == alloc_q1);
    assign byp2     = cdb_valid && (cdb_tag == alloc_q2);

    always_comb begin
        busy_d = busy_q;
        r1_d   = r1_q;
        r2_d   = r2_q;
        op_d   = op_q;
        q1_d   = q1_q;
        q2_d   = q2_q;
        v1_d   = v1_q;
        v2_d   = v2_q;
        cnt_d  = cnt_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (busy_q[i] && !r1_q[i] && cdb_valid
                && q1_q[i] == cdb_tag) begin
                v1_d[i] = cdb_data;
                r1_d[i] = 1'b1;
            end
            if (busy_q[i] && !r2_q[i] && cdb_valid
                && q2_q[i] == cdb_tag) begin
                v2_d[i] = cdb_data;
                r2_d[i] = 1'b1;
            end
        end
        if (do_issue) busy_d[iss_idx] = 1'b0;
        if (do_alloc) begin
            busy_d[free_idx] = 1'b1;
            op_d[free_idx]   = alloc_op;
            q1_d[free_idx]   = alloc_q1;
            q2_d[free_idx]   = alloc_q2;
            r1_d[free_idx]   = alloc_r1 | byp1;
            r2_d[free_idx]   = alloc_r2 | byp2;
            v1_d[free_idx]   = alloc_r1 ? alloc_v1 : cdb_data;
            v2_d[free_idx]   = alloc_r2 ? alloc_v2 : cdb_data;
        end
        unique case (1'b1)
            flush:                 cnt_d = '0;
            do_alloc && !do_issue: cnt_d = cnt_q + CW'(1);
            do_issue && !do_alloc: cnt_d = cnt_q - CW'(1);
            default:               cnt_d = cnt_q;
        endcase
        if (flush) busy_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
        r1_q <= r1_d;
        r2_q <= r2_d;
        op_q <= op_d;
        q1_q <= q1_d;
        q2_q <= q2_d;
        v1_q <= v1_d;
        v2_q <= v2_d;
    end

endmodule

// File: tb/tb_rs_bank.sv
// Scoreboard bench for rs_bank: directed allocations and CDB broadcasts,
// with issued packets checked against a queue of expected results.
module tb_rs_bank;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alloc_valid = 1'b0;
    logic        alloc_ready;
    logic [1:0]  alloc_op = '0;
    logic [7:0]  alloc_q1 = '0;
    logic [31:0] alloc_v1 = '0;
    logic        alloc_r1 = 1'b0;
    logic [7:0]  alloc_q2 = '0;
    logic [31:0] alloc_v2 = '0;
    logic        alloc_r2 = 1'b0;
    logic [7:0]  alloc_tag;
    logic        cdb_valid = 1'b0;
    logic [7:0]  cdb_tag = '0;
    logic [31:0] cdb_data = '0;
    logic        issue_valid;
    logic        issue_ready = 1'b0;
    logic [1:0]  issue_op;
    logic [31:0] issue_a;
    logic [31:0] issue_b;
    logic [7:0]  issue_tag;
    logic        flush = 1'b0;
    logic [3:0]  count;

    rs_bank dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
        .alloc_op(alloc_op),
        .alloc_q1(alloc_q1), .alloc_v1(alloc_v1), .alloc_r1(alloc_r1),
        .alloc_q2(alloc_q2), .alloc_v2(alloc_v2), .alloc_r2(alloc_r2),
        .alloc_tag(alloc_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_op(issue_op), .issue_a(issue_a), .issue_b(issue_b),
        .issue_tag(issue_tag),
        .flush(flush), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [7:0]  tag;
    } exp_t;

    exp_t sbq[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Monitor: every accepted issue must match the oldest expectation.
    always @(negedge clk) begin
        exp_t got;
        exp_t e;
        if (!rst && !flush && issue_valid && issue_ready) begin
            got = '{issue_op, issue_a, issue_b, issue_tag};
            n_vec++;
            if (sbq.size() == 0) begin
                n_err++;
                $display("FAIL issue_extra got tag=%h a=%0d b=%0d",
                         issue_tag, issue_a, issue_b);
            end else begin
                e = sbq.pop_front();
                if (got !== e) begin
                    n_err++;
                    $display({"FAIL issue_pkt got op=%0d a=%0d b=%0d",
                              " tag=%h exp op=%0d a=%0d b=%0d tag=%h"},
                             got.op, got.a, got.b, got.tag,
                             e.op, e.a, e.b, e.tag);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", nm, act, exp);
        end
    endtask

    task automatic set_alloc(
        input logic [1:0] op,
        input logic [7:0] q1, input logic [31:0] v1, input logic r1,
        input logic [7:0] q2, input logic [31:0] v2, input logic r2
    );
        alloc_valid = 1'b1;
        alloc_op = op;
        alloc_q1 = q1; alloc_v1 = v1; alloc_r1 = r1;
        alloc_q2 = q2; alloc_v2 = v2; alloc_r2 = r2;
    endtask

    task automatic push(input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [7:0] tag);
        sbq.push_back('{op, a, b, tag});
    endtask

    task automatic bcast(input logic [7:0] t, input logic [31:0] d);
        cdb_valid = 1'b1;
        cdb_tag   = t;
        cdb_data  = d;
    endtask

    initial begin
        repeat (2) step();
        rst = 1'b0;
        chk("rst_count", 32'(count), 0);
        chk("rst_aready", 32'(alloc_ready), 1);
        chk("rst_ivalid", 32'(issue_valid), 0);
        chk("rst_atag", 32'(alloc_tag), 32'h20);

        // ready-at-alloc instruction issues next cycle
        set_alloc(2'd0, 8'h0, 5, 1'b1, 8'h0, 7, 1'b1);
        step();
        alloc_valid = 1'b0;
        chk("t1_ivalid", 32'(issue_valid), 1);
        chk("t1_itag", 32'(issue_tag), 32'h20);
        push(2'd0, 5, 7, 8'h20);
        issue_ready = 1'b1;
        step();
        issue_ready = 1'b0;
        chk("t1_count", 32'(count), 0);
        chk("t1_ivalid0", 32'(issue_valid), 0);

        // CDB wakeup of a waiting src1
        set_alloc(2'd1, 8'h40, 0, 1'b0, 8'h0, 3, 1'b1);
        step();
        alloc_valid = 1'b0;
        step();
        step();
        chk("t2_wait", 32'(issue_valid), 0);
        chk("t2_count", 32'(count), 1);
        bcast(8'h40, 9);
        step();
        cdb_valid = 1'b0;
        chk("t2_woke", 32'(issue_valid), 1);
        push(2'd1, 9, 3, 8'h20);
        issue_ready = 1'b1;
        step();
        issue_ready = 1'b0;

        // bypass at allocation, then alloc+issue in one cycle
        set_alloc(2'd2, 8'h41, 0, 1'b0, 8'h0, 4, 1'b1);
        bcast(8'h41, 11);
        step();
        alloc_valid = 1'b0;
        cdb_valid = 1'b0;
        chk("t3_ivalid", 32'(issue_valid), 1);
        chk("t3_a", issue_a, 11);
        push(2'd2, 11, 4, 8'h20);
        set_alloc(2'd3, 8'h0, 8, 1'b1, 8'h0, 9, 1'b1);
        chk("t3_atag", 32'(alloc_tag), 32'h21);
        issue_ready = 1'b1;
        step();
        alloc_valid = 1'b0;
        issue_ready = 1'b0;
        chk("t3_count_hold", 32'(count), 1);
        chk("t3_itag", 32'(issue_tag), 32'h21);
        push(2'd3, 8, 9, 8'h21);
        issue_ready = 1'b1;
        step();
        issue_ready = 1'b0;
        chk("t3_count0", 32'(count), 0);

        // fill the bank, overflow alloc ignored, drain in order
        for (int i = 0; i < 8; i++) begin
            chk("t4_atag", 32'(alloc_tag), 32'h20 + 32'(i));
            set_alloc(2'd1, 8'h50, 0, 1'b0, 8'h0, 32'(i), 1'b1);
            step();
        end
        chk("t4_full_count", 32'(count), 8);
        chk("t4_aready", 32'(alloc_ready), 0);
        set_alloc(2'd1, 8'h50, 0, 1'b0, 8'h0, 99, 1'b1);
        step();
        alloc_valid = 1'b0;
        chk("t4_ignored", 32'(count), 8);
        bcast(8'h50, 100);
        step();
        cdb_valid = 1'b0;
        for (int i = 0; i < 8; i++) push(2'd1, 100, 32'(i), 8'h20 + 8'(i));
        issue_ready = 1'b1;
        for (int k = 0; k < 20 && count != 0; k++) step();
        issue_ready = 1'b0;
        chk("t4_drained", 32'(count), 0);
        chk("t4_sb_empty", 32'(sbq.size()), 0);

        // stall with entries 2 and 5 ready; lower wakeup takes over
        set_alloc(2'd0, 8'h60, 0, 1'b0, 8'h0, 10, 1'b1);
        step();
        set_alloc(2'd1, 8'h61, 0, 1'b0, 8'h0, 11, 1'b1);
        step();
        set_alloc(2'd2, 8'h0, 2, 1'b1, 8'h0, 22, 1'b1);
        step();
        set_alloc(2'd1, 8'h62, 0, 1'b0, 8'h0, 33, 1'b1);
        step();
        set_alloc(2'd1, 8'h63, 0, 1'b0, 8'h0, 44, 1'b1);
        step();
        set_alloc(2'd3, 8'h0, 5, 1'b1, 8'h0, 55, 1'b1);
        step();
        alloc_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("t5_stall_tag", 32'(issue_tag), 32'h22);
            step();
        end
        bcast(8'h60, 6);
        step();
        cdb_valid = 1'b0;
        chk("t5_new_tag", 32'(issue_tag), 32'h20);
        chk("t5_new_a", issue_a, 6);
        push(2'd0, 6, 10, 8'h20);
        push(2'd2, 2, 22, 8'h22);
        push(2'd3, 5, 55, 8'h25);
        issue_ready = 1'b1;
        repeat (3) step();
        issue_ready = 1'b0;
        chk("t5_count", 32'(count), 3);
        chk("t5_ivalid", 32'(issue_valid), 0);

        // flush beats alloc, wakeup and a live handshake
        bcast(8'h61, 1);
        step();
        cdb_valid = 1'b0;
        chk("t6_pre_ivalid", 32'(issue_valid), 1);
        flush = 1'b1;
        set_alloc(2'd0, 8'h0, 1, 1'b1, 8'h0, 1, 1'b1);
        issue_ready = 1'b1;
        bcast(8'h62, 2);
        step();
        flush = 1'b0;
        alloc_valid = 1'b0;
        issue_ready = 1'b0;
        cdb_valid = 1'b0;
        chk("t6_count", 32'(count), 0);
        chk("t6_ivalid", 32'(issue_valid), 0);
        chk("t6_atag", 32'(alloc_tag), 32'h20);
        chk("t6_aready", 32'(alloc_ready), 1);

        // reset while entries wait
        set_alloc(2'd1, 8'h70, 0, 1'b0, 8'h0, 1, 1'b1);
        step();
        set_alloc(2'd1, 8'h71, 0, 1'b0, 8'h0, 2, 1'b1);
        step();
        alloc_valid = 1'b0;
        chk("t6r_count2", 32'(count), 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6r_count", 32'(count), 0);
        chk("t6r_ivalid", 32'(issue_valid), 0);
        chk("t6r_atag", 32'(alloc_tag), 32'h20);
        bcast(8'h70, 7);
        step();
        cdb_valid = 1'b0;
        chk("t6r_no_wake", 32'(issue_valid), 0);

        repeat (3) step();
        chk("final_sb_empty", 32'(sbq.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
